// File: rtl/multi_clk_en_gen_pkg.sv
// Shared types for the multi-channel clock-enable generator.
// CE_DIV_W fixes the divider width carried in ce_cfg_t.
package clk_en_pkg;
    parameter int CE_DIV_W = 16;

    typedef enum logic {CE_PULSE = 1'b0, CE_SQUARE = 1'b1} ce_mode_e;

    typedef struct packed {
        logic [CE_DIV_W-1:0] div;
        ce_mode_e            mode;
    } ce_cfg_t;

    // Divide value 0 behaves as 1, so the terminal count is never negative.
    function automatic logic [CE_DIV_W-1:0] ce_tc_val(input logic [CE_DIV_W-1:0] div);
        return (div == '0) ? '0 : div - CE_DIV_W'(1);
    endfunction
endpackage

// File: rtl/multi_clk_en_gen_if.sv
// Config/sync bus and per-channel outputs of multi_clk_en_gen.
interface multi_clk_en_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              sync_i;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] en_o;
    logic [NUM_CH-1:0] pending_o;

    modport master (output sync_i, cfg_we, cfg_ch, cfg_div, cfg_mode,
                    input  en_o, pending_o);
    modport slave  (input  sync_i, cfg_we, cfg_ch, cfg_div, cfg_mode,
                    output en_o, pending_o);
endinterface

// File: rtl/multi_clk_en_gen_channel.sv
// One enable channel: wrap counter, active/shadow config, pending flag, registered output.
// Shadow config is only promoted at a terminal count or on sync.
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter ce_cfg_t RST_CFG = '0
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    sync,
    input  logic    wr_en,
    input  ce_cfg_t wr_cfg,
    output logic    en,
    output logic    pending
);
    ce_cfg_t             active_q, shadow_q;
    logic [CE_DIV_W-1:0] cnt_q;
    logic                phase_q;
    logic                tc;

    assign tc = (cnt_q == ce_tc_val(active_q.div));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            active_q <= RST_CFG;
            shadow_q <= '0;
            pending  <= 1'b0;
            en       <= 1'b0;
            phase_q  <= 1'b0;
        end else if (sync) begin
            // A write coincident with sync bypasses the shadow entirely.
            cnt_q   <= '0;
            en      <= 1'b0;
            phase_q <= 1'b0;
            pending <= 1'b0;
            if (wr_en)
                active_q <= wr_cfg;
            else if (pending)
                active_q <= shadow_q;
        end else begin
            cnt_q <= tc ? '0 : cnt_q + CE_DIV_W'(1);
            if (active_q.mode == CE_PULSE) begin
                en      <= tc;
                phase_q <= 1'b0;
            end else begin
                en      <= phase_q ^ tc;
                phase_q <= phase_q ^ tc;
            end
            // A write landing on TC defers the apply so the last write wins.
            if (wr_en) begin
                shadow_q <= wr_cfg;
                pending  <= 1'b1;
            end else if (tc && pending) begin
                active_q <= shadow_q;
                pending  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/multi_clk_en_gen.sv
// Multi-channel programmable clock-enable generator: decodes config writes
// into per-channel strobes and fans sync out to every channel.
module multi_clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = CE_DIV_W,
    parameter int DIV_RESET  = 4,
    parameter int MODE_RESET = 0
) (
    input logic               clk,
    input logic               reset_n,
    multi_clk_en_gen_if.slave bus
);
    localparam int      CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam ce_cfg_t RST_CFG = '{div: CE_DIV_W'(DIV_RESET), mode: ce_mode_e'(MODE_RESET[0])};

    ce_cfg_t           wr_cfg;
    logic [NUM_CH-1:0] wr_en;

    assign wr_cfg = '{div: CE_DIV_W'(bus.cfg_div), mode: ce_mode_e'(bus.cfg_mode)};

    // Out-of-range channel numbers match no strobe and are dropped.
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            assign wr_en[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

            clk_en_channel #(.RST_CFG(RST_CFG)) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .sync    (bus.sync_i),
                .wr_en   (wr_en[i]),
                .wr_cfg  (wr_cfg),
                .en      (bus.en_o[i]),
                .pending (bus.pending_o[i])
            );
        end
    endgenerate
endmodule
